// File: rtl/chunked_add_seq_pkg.sv
// Shared types and elaboration helpers for the chunked wide adder/subtractor sequencer.
package chunked_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/chunked_add_seq_chunk.sv
// Combinational CHUNK-bit adder slice: {cout, sum} = a + b + cin.
module chunk_add_cin #(
    parameter int unsigned CHUNK = 32
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle wide add/subtract: one CHUNK-bit slice reused LS chunk first, carry registered
// between chunks, valid/ready handshake on request and response.
module chunked_add_seq
    import chunked_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    input  logic             req_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
    localparam int unsigned IDXW       = idx_width(NUM_CHUNKS);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("chunked_add_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t state_q, state_d;

    // Operands and result held as chunk arrays so idx_q selects a slice directly.
    logic [NUM_CHUNKS-1:0][CHUNK-1:0] a_q, b_q, sum_q;
    logic [IDXW-1:0]                  idx_q;
    logic                             carry_q;
    logic                             cout_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    chunk_add_cin #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a_i   (a_q[idx_q]),
        .b_i   (b_q[idx_q]),
        .cin_i (carry_q),
        .sum_o (slice_sum),
        .cout_o(slice_cout)
    );

    assign last = (idx_q == IDXW'(NUM_CHUNKS - 1));

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= req_a;
            b_q     <= req_sub ? ~req_b : req_b;
            carry_q <= req_sub ? 1'b1 : req_cin;
            idx_q   <= '0;
        end else if (state_q == BUSY) begin
            sum_q[idx_q] <= slice_sum;
            carry_q      <= slice_cout;
            if (last) begin
                cout_q <= slice_cout;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + IDXW'(1);
            end
        end
    end

    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Bench for chunked_add_seq: three instances (CHUNK=32/64/128, WIDTH=128) driven in lockstep.
module tb_chunked_add_seq;

    localparam int W    = 128;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0;
    logic         req_cin   = 1'b0;
    logic         req_sub   = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] req_a     = '0;
    logic [W-1:0] req_b     = '0;

    logic         rdy  [NDUT];
    logic         vld  [NDUT];
    logic         cout [NDUT];
    logic         bsy  [NDUT];
    logic [W-1:0] sum  [NDUT];

    int nch [NDUT] = '{4, 2, 1};

    chunked_add_seq #(.WIDTH(W), .CHUNK(32)) u_c32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_sum(sum[0]),
        .rsp_cout(cout[0]), .busy(bsy[0]));

    chunked_add_seq #(.WIDTH(W), .CHUNK(64)) u_c64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_sum(sum[1]),
        .rsp_cout(cout[1]), .busy(bsy[1]));

    chunked_add_seq #(.WIDTH(W), .CHUNK(128)) u_c128 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_sum(sum[2]),
        .rsp_cout(cout[2]), .busy(bsy[2]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int d, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    // Reference: unbounded integer arithmetic, reduced modulo 2^W; sub carry = no borrow.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        end
        return r;
    endfunction

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [W-1:0] s, input logic c);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sum = s; v.cout = c;
        vecs.push_back(v);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        for (int d = 0; d < NDUT; d++) chk("accept_ready", d, (W+1)'(rdy[d]), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble inputs after accept: results must depend only on the accepted values.
        req_a = ~a; req_b = {$urandom, $urandom, $urandom, $urandom}; req_cin = ~cin; req_sub = ~sub;
    endtask

    task automatic wait_rsp(input string name, input logic [W-1:0] es, input logic ec);
        int lat [NDUT];
        int k;
        lat = '{0, 0, 0};
        k = 0;
        while (k < 20 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
            @(posedge clk); #1;
            k++;
            for (int d = 0; d < NDUT; d++)
                if (vld[d] === 1'b1 && lat[d] == 0) lat[d] = k;
        end
        for (int d = 0; d < NDUT; d++) begin
            chk({name, "_latency"}, d, (W+1)'(lat[d]), (W+1)'(nch[d]));
            chk({name, "_result"}, d, {cout[d], sum[d]}, {ec, es});
            chk({name, "_busy"}, d, (W+1)'(bsy[d]), 1);
        end
    endtask

    task automatic release_rsp(input string name, input logic [W-1:0] es, input logic ec);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            chk({name, "_idle_valid"}, d, (W+1)'(vld[d]), 0);
            chk({name, "_idle_ready"}, d, {1'b0, {(W-1){1'b0}}, rdy[d] & ~bsy[d]}, 1);
            chk({name, "_hold"}, d, {cout[d], sum[d]}, {ec, es});
        end
    endtask

    logic [W-1:0] ones;
    logic [W:0]   e1, e2;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           sel;

    initial begin
        ones = '1;
        add_vec("max_plus_one", ones, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1);
        add_vec("chunk_ripple", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
                128'h00000001_00000000_00000000_00000000, 1'b0);
        add_vec("sub_5_7", 128'd5, 128'd7, 1'b0, 1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0);
        add_vec("sub_7_5", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1);
        add_vec("sub_cin_ignored", 128'd7, 128'd5, 1'b1, 1'b1, 128'd2, 1'b1);
        add_vec("cin_only", 128'd0, 128'd0, 1'b1, 1'b0, 128'd1, 1'b0);
        add_vec("cin_full_ripple", ones, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1);
        add_vec("sub_equal", 128'h1234_5678_9ABC_DEF0, 128'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 128'd0, 1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_ready", d, (W+1)'(rdy[d]), 1);
            chk("rst_valid", d, (W+1)'(vld[d]), 0);
            chk("rst_busy", d, (W+1)'(bsy[d]), 0);
            chk("rst_result", d, {cout[d], sum[d]}, '0);
        end
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of an operation (CHUNK=32 instance at idx 2)
        issue(ones, 128'd1, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_pre_valid", 0, (W+1)'(vld[0]), 0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("abort_valid", d, (W+1)'(vld[d]), 0);
            chk("abort_ready", d, (W+1)'(rdy[d]), 1);
            chk("abort_busy", d, (W+1)'(bsy[d]), 0);
            chk("abort_result", d, {cout[d], sum[d]}, '0);
        end
        #3 rst = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin
            @(posedge clk); #1;
            for (int d = 0; d < NDUT; d++) begin
                chk("abort_no_rsp", d, (W+1)'(vld[d]), 0);
                chk("abort_idle", d, (W+1)'(rdy[d]), 1);
            end
        end

        // Directed vectors
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_rsp(vecs[i].name, vecs[i].sum, vecs[i].cout);
            release_rsp(vecs[i].name, vecs[i].sum, vecs[i].cout);
        end

        // Backpressure with a pending request held throughout
        e1 = ref_op(128'hDEAD_BEEF_0000_0001_FFFF_FFFF_8000_0000, 128'h0123_4567_89AB_CDEF_0000_0001_8000_0000, 1'b1, 1'b0);
        e2 = ref_op(128'd100, 128'd300, 1'b0, 1'b1);
        issue(128'hDEAD_BEEF_0000_0001_FFFF_FFFF_8000_0000, 128'h0123_4567_89AB_CDEF_0000_0001_8000_0000, 1'b1, 1'b0);
        wait_rsp("bp_first", e1[W-1:0], e1[W]);
        req_a = 128'd100; req_b = 128'd300; req_cin = 1'b0; req_sub = 1'b1; req_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            for (int d = 0; d < NDUT; d++) begin
                chk("bp_valid", d, (W+1)'(vld[d]), 1);
                chk("bp_ready", d, (W+1)'(rdy[d]), 0);
                chk("bp_stable", d, {cout[d], sum[d]}, e1);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            chk("bp_drop_valid", d, (W+1)'(vld[d]), 0);
            chk("bp_back_idle", d, (W+1)'(rdy[d]), 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            chk("bp_accepted_busy", d, (W+1)'(bsy[d]), 1);
            chk("bp_accepted_ready", d, (W+1)'(rdy[d]), 0);
        end
        wait_rsp("bp_second", e2[W-1:0], e2[W]);
        release_rsp("bp_second", e2[W-1:0], e2[W]);

        // Random operations against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra  = {$urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            rc  = 1'($urandom);
            rs  = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) ra = '1;
            if (sel == 1) rb = ~ra;
            if (sel == 2) rb = ra;
            e1 = ref_op(ra, rb, rc, rs);
            issue(ra, rb, rc, rs);
            wait_rsp("rand", e1[W-1:0], e1[W]);
            release_rsp("rand", e1[W-1:0], e1[W]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
